// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Optional transfer watchdog is enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]   GRANT,
    output logic [NUM_REQ-1:0]   DONE,
    output logic                 TXBegin,
    output logic [7:0]           TX_DATA,
    input  logic                 TXComplete,
    output logic                 BUSY,
    output logic                 TIMEOUT
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   pick_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] done_r;
    logic               txbegin_r;
    logic               busy_r;
    logic [7:0]         tx_data_r;
    logic               wdog_hit_s;

    // Scan from last+1 upward with wrap; descending loop lets the nearest requester win.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                pick = IDX_W'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef UART_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
    logic [15:0] wdog_r;
    logic        timeout_r;

    assign wdog_hit_s = (wdog_r == WDOG_LIMIT);

    // Watchdog counter: cleared on the START->WAIT edge, counts each WAIT cycle.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wdog_r    <= 16'h0000;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= (state_r == WAIT) && wdog_hit_s && !TXComplete;
            if (state_r == START) begin
                wdog_r <= 16'h0000;
            end else if (state_r == WAIT) begin
                wdog_r <= wdog_r + 16'h0001;
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    assign TIMEOUT = timeout_r;
`else
    assign wdog_hit_s = 1'b0;
    assign TIMEOUT    = 1'b0;
`endif

    // Combinational winner selection for the IDLE cycle.
    always_comb begin
        pick_s = rr_pick(REQ, last_r);
    end

    // State register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; TXComplete only matters while waiting.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|REQ) state_s = START;
                else      state_s = IDLE;
            end
            START:   state_s = WAIT;
            WAIT: begin
                if (TXComplete || wdog_hit_s) state_s = RELEASE;
                else                          state_s = WAIT;
            end
            RELEASE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered outputs, owner capture and round-robin pointer.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            grant_r   <= '0;
            done_r    <= '0;
            txbegin_r <= 1'b0;
            busy_r    <= 1'b0;
            tx_data_r <= 8'h00;
            owner_r   <= '0;
            last_r    <= IDX_W'(NUM_REQ - 1);
        end else begin
            txbegin_r <= (state_s == START);
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == RELEASE) ? grant_r : '0;
            if ((state_r == IDLE) && (state_s == START)) begin
                grant_r   <= onehot(pick_s);
                owner_r   <= pick_s;
                tx_data_r <= REQ_DATA[int'(pick_s)*8 +: 8];
            end else if (state_r == RELEASE) begin
                grant_r <= '0;
                last_r  <= owner_r;
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    assign GRANT   = grant_r;
    assign DONE    = done_r;
    assign TXBegin = txbegin_r;
    assign TX_DATA = tx_data_r;
    assign BUSY    = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, transfer handshake,
// async reset abort and the watchdog / no-watchdog behaviour.
module tb_uart_tx_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [31:0] REQ_DATA;
    logic [3:0]  GRANT;
    logic [3:0]  DONE;
    logic        TXBegin;
    logic [7:0]  TX_DATA;
    logic        TXComplete;
    logic        BUSY;
    logic        TIMEOUT;

    int n_cmp = 0;
    int n_err = 0;
    logic seen_to;

    uart_tx_arbiter #(.NUM_REQ(4), .WDOG_CYCLES(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .REQ_DATA(REQ_DATA),
        .GRANT(GRANT), .DONE(DONE), .TXBegin(TXBegin), .TX_DATA(TX_DATA),
        .TXComplete(TXComplete), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic cyc();
        @(negedge CLOCK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
    endtask

    // From a negedge in IDLE with REQ pending: one full transfer, ending at a negedge in IDLE.
    task automatic xfer(input string tag, input logic [3:0] g, input logic [7:0] d);
        cyc();
        chk({tag, "_grant"}, GRANT, g);
        chk({tag, "_data"}, TX_DATA, d);
        chk({tag, "_begin"}, TXBegin, 1'b1);
        cyc();
        chk({tag, "_begin_off"}, TXBegin, 1'b0);
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        chk({tag, "_done"}, DONE, g);
        chk({tag, "_grant_rel"}, GRANT, g);
        cyc();
        chk({tag, "_idle_grant"}, GRANT, 4'b0000);
        chk({tag, "_idle_done"}, DONE, 4'b0000);
    endtask

    initial begin
        RESET = 1'b1; REQ = 4'b0000; REQ_DATA = 32'h0; TXComplete = 1'b0;
        cyc(); cyc();
        RESET = 1'b0;
        chk("rst_grant", GRANT, 4'b0000);
        chk("rst_done", DONE, 4'b0000);
        chk("rst_begin", TXBegin, 1'b0);
        chk("rst_data", TX_DATA, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_timeout", TIMEOUT, 1'b0);

        // Single requester 0, byte A5.
        REQ = 4'b0001; REQ_DATA = 32'h0000_00A5;
        cyc();
        chk("single_grant", GRANT, 4'b0001);
        chk("single_data", TX_DATA, 8'hA5);
        chk("single_begin", TXBegin, 1'b1);
        chk("single_busy", BUSY, 1'b1);
        cyc();
        chk("single_begin_off", TXBegin, 1'b0);
        chk("single_nodone", DONE, 4'b0000);
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        REQ = 4'b0000;
        chk("single_done", DONE, 4'b0001);
        cyc();
        chk("single_done_off", DONE, 4'b0000);
        chk("single_busy_off", BUSY, 1'b0);

        // All requesting: order 0,1,2,3,0 with bytes following.
        do_reset();
        REQ = 4'b1111; REQ_DATA = 32'h4433_2211;
        xfer("rr0", 4'b0001, 8'h11);
        xfer("rr1", 4'b0010, 8'h22);
        xfer("rr2", 4'b0100, 8'h33);
        xfer("rr3", 4'b1000, 8'h44);
        xfer("rr4", 4'b0001, 8'h11);

        // Owner 2 with 0 and 2 requesting: wrap to 0, skipping 3.
        do_reset();
        REQ = 4'b0100;
        cyc();
        chk("wrap_own2", GRANT, 4'b0100);
        REQ = 4'b0101;
        cyc();
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        chk("wrap_done2", DONE, 4'b0100);
        cyc();
        REQ = 4'b0101;
        xfer("wrap_to0", 4'b0001, 8'h11);

        // TXComplete ignored in IDLE and START.
        REQ = 4'b0000;
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        chk("ign_idle_busy", BUSY, 1'b0);
        chk("ign_idle_done", DONE, 4'b0000);
        REQ = 4'b0010;
        cyc();
        chk("ign_start_grant", GRANT, 4'b0010);
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        REQ_DATA = 32'hDEAD_BEEF;
        chk("ign_start_busy", BUSY, 1'b1);
        chk("ign_start_done", DONE, 4'b0000);
        cyc();
        chk("ign_wait_done", DONE, 4'b0000);
        chk("hold_data", TX_DATA, 8'h22);
        REQ = 4'b0000;
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        chk("ign_final_done", DONE, 4'b0010);
        chk("hold_grant", GRANT, 4'b0010);
        cyc();
        REQ_DATA = 32'h4433_2211;

        // Async reset during WAIT.
        REQ = 4'b1000;
        cyc();
        chk("arst_grant3", GRANT, 4'b1000);
        cyc();
        RESET = 1'b1;
        #1;
        chk("arst_grant", GRANT, 4'b0000);
        chk("arst_busy", BUSY, 1'b0);
        cyc();
        chk("arst_nodone", DONE, 4'b0000);
        RESET = 1'b0;
        REQ = 4'b1001;
        xfer("arst_after", 4'b0001, 8'h11);

        // Watchdog (macro on) or indefinite WAIT (macro off); last owner is 0 so 1 wins.
        REQ = 4'b0010;
        cyc();
        chk("wd_grant", GRANT, 4'b0010);
        cyc();
`ifdef UART_ARB_WATCHDOG_EN
        seen_to = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            seen_to = seen_to | TIMEOUT | (|DONE);
        end
        chk("wd_early", seen_to, 1'b0);
        cyc();
        chk("wd_timeout", TIMEOUT, 1'b1);
        chk("wd_done", DONE, 4'b0010);
        REQ = 4'b0000;
        cyc();
        chk("wd_timeout_off", TIMEOUT, 1'b0);
        chk("wd_grant_off", GRANT, 4'b0000);
`else
        seen_to = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            seen_to = seen_to | TIMEOUT | (|DONE) | ~BUSY;
        end
        chk("nowd_stuck", seen_to, 1'b0);
        chk("nowd_busy", BUSY, 1'b1);
        REQ = 4'b0000;
        TXComplete = 1'b1;
        cyc();
        TXComplete = 1'b0;
        chk("nowd_done", DONE, 4'b0010);
        chk("nowd_timeout", TIMEOUT, 1'b0);
        cyc();
        chk("nowd_idle", BUSY, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter WDOG_CYCLES, default 65535, SHALL set the watchdog limit in CLOCK cycles (16-bit).
REQ-003 CLOCK  in  1  SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 RESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 REQ  in  NUM_REQ  SHALL carry one transmit request per requester.
REQ-006 REQ_DATA  in  8*NUM_REQ  SHALL carry the byte for requester i on bits [8i+7:8i].
REQ-007 GRANT  out  NUM_REQ  SHALL be the one-hot current owner, or all-zero when no owner.
REQ-008 DONE  out  NUM_REQ  SHALL pulse for 1 cycle at the bit of the requester whose byte finished.
REQ-009 TXBegin  out  1  SHALL be the start pulse to the Transmitter.
REQ-010 TX_DATA  out  8  SHALL be the byte presented to the Transmitter.
REQ-011 TXComplete  in  1  SHALL be the Transmitter's 1-cycle completion pulse.
REQ-012 BUSY  out  1  SHALL be high whenever state is not IDLE.
REQ-013 TIMEOUT  out  1  SHALL pulse for 1 cycle when the watchdog aborts a transfer.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, RELEASE.
REQ-015 IDLE: if any REQ bit is high, the winner SHALL be selected round-robin, scanning from LAST+1 mod NUM_REQ upward with wrap.
REQ-016 IDLE -> START: the winner's GRANT bit and its REQ_DATA byte (into TX_DATA) SHALL be registered on the same edge; REQ sampled at cycle n gives GRANT at n+1.
REQ-017 START: TXBegin SHALL be high for exactly this one cycle; next state WAIT.
REQ-018 WAIT: on TXComplete, next state SHALL be RELEASE; TXComplete in IDLE, START or RELEASE SHALL be ignored.
REQ-019 RELEASE: DONE[owner] SHALL be high for this one cycle, GRANT SHALL clear and LAST SHALL update to the owner on the exit edge; next state IDLE.
REQ-020 TX_DATA and GRANT SHALL stay stable from START until leaving RELEASE.
REQ-021 REQ_DATA SHALL be sampled only on the grant edge; later changes SHALL not affect TX_DATA.
REQ-022 Requesters SHALL hold REQ until DONE; deasserting REQ after grant SHALL NOT abort the transfer.
REQ-023 A requester still requesting after its DONE SHALL rank lowest in the next arbitration.
REQ-024 Back-to-back throughput: minimum 4 cycles plus Transmitter time per byte; IDLE lasts 1 cycle when REQ is pending.

Reset
REQ-025 RESET SHALL force state IDLE, GRANT=0, DONE=0, TXBegin=0, TX_DATA=8'h00, BUSY=0, TIMEOUT=0, watchdog counter=0 and LAST=NUM_REQ-1, so requester 0 wins first.
REQ-026 RESET during START/WAIT/RELEASE SHALL drop GRANT immediately with no DONE pulse for the aborted byte.

Configuration
REQ-027 With UART_ARB_WATCHDOG_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-028 If that counter reaches WDOG_CYCLES-1 without TXComplete, the next state SHALL be RELEASE, with TIMEOUT and DONE[owner] pulsing together.
REQ-029 If TXComplete arrives on the limit cycle, completion SHALL win and TIMEOUT SHALL stay 0.
REQ-030 Without UART_ARB_WATCHDOG_EN, WAIT SHALL last indefinitely and TIMEOUT SHALL be tied 0; the port remains.

Verification
REQ-031 Reset, then REQ=4'b0001 with byte0=8'hA5 -> GRANT=0001 and TX_DATA=A5 next cycle, one TXBegin pulse, then DONE=0001 one cycle after TXComplete.
REQ-032 REQ=4'b1111 held with bytes 11,22,33,44 -> grant order 0,1,2,3,0; TX_DATA follows 11,22,33,44,11.
REQ-033 Owner 2 with REQ=4'b0101 held -> next grant SHALL go to 0 via wrap; 3 is skipped.
REQ-034 TXComplete pulsed in IDLE and in START -> no state change; transfer ends only on the WAIT-state pulse.
REQ-035 RESET asserted mid-WAIT -> GRANT=0 and BUSY=0 asynchronously, no DONE, requester 0 wins after release.
REQ-036 Macro on, WDOG_CYCLES=16, no TXComplete -> TIMEOUT and DONE pulse 16 cycles after WAIT entry; macro off -> BUSY stays 1.
